// File: rtl/mmu_seq_ctrl.sv
// Sequencer that streams input-bank bytes into the MMU core and stores its
// 9-bit results into the output bank, with timeout and overflow reporting.
module mmu_seq_ctrl #(
  parameter int IN_WORDS  = 64,
  parameter int OUT_WORDS = 160,
  parameter int TIMEOUT   = 4096
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        start_i,
  input  logic [8:0]  len_i,
  output logic [5:0]  in_rd_addr_o,
  input  logic [31:0] in_rd_data_i,
  output logic [7:0]  mmu_input_data_o,
  output logic        mmu_valid_input_o,
  input  logic        mmu_read_ram_i,
  input  logic [8:0]  mmu_read_data_i,
  input  logic        mmu_finish_i,
  output logic        out_wr_en_o,
  output logic [7:0]  out_wr_addr_o,
  output logic [31:0] out_wr_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  out_cnt_o
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]     OUT_MAX  = 8'(OUT_WORDS);
  localparam logic [WCW-1:0] WAIT_END = WCW'(TIMEOUT - 1);

  // A 256-byte job addresses 64 words; a smaller bank cannot hold it.
  if (IN_WORDS < 64) begin : g_bad_in_words
    $error("mmu_seq_ctrl: IN_WORDS must be at least 64");
  end

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [8:0]     len_q, len_d;
  logic [8:0]     idx_q, idx_d;
  logic [5:0]     addr_q, addr_d;
  logic [7:0]     out_cnt_q, out_cnt_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           capture;
  logic           wr_en;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      out_cnt_q <= '0;
      wait_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      out_cnt_q <= out_cnt_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    out_cnt_d = out_cnt_q;
    wait_d    = wait_q;
    done_d    = done_q;
    err_d     = err_q;
    capture   = ((state_q == FEED) || (state_q == WAIT)) && mmu_read_ram_i;
    wr_en     = capture && (out_cnt_q != OUT_MAX);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d     = len_i;
          idx_d     = '0;
          out_cnt_d = '0;
          wait_d    = '0;
          done_d    = 1'b0;
          err_d     = 1'b0;
          if (len_i == 9'd0) begin
            state_d = WAIT;
          end else if (len_i > 9'd256) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = FEED;
          end
        end
      end
      FEED: begin
        addr_d = idx_q[7:2];
        idx_d  = idx_q + 9'd1;
        if (mmu_finish_i) err_d = 1'b1;
        if (idx_q == len_q - 9'd1) begin
          state_d = WAIT;
          wait_d  = '0;
        end
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        if (mmu_finish_i) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (wait_q == WAIT_END) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A full output bank drops the result and flags it instead of wrapping.
    if (capture) begin
      if (wr_en) out_cnt_d = out_cnt_q + 8'd1;
      else       err_d     = 1'b1;
    end
  end

  assign in_rd_addr_o      = (state_q == FEED) ? idx_q[7:2] : addr_q;
  assign mmu_valid_input_o = (state_q == FEED);
  assign mmu_input_data_o  = (state_q == FEED) ? in_rd_data_i[{idx_q[1:0], 3'b000} +: 8] : 8'd0;
  assign out_wr_en_o       = wr_en;
  assign out_wr_addr_o     = out_cnt_q;
  assign out_wr_data_o     = wr_en ? {23'b0, mmu_read_data_i} : 32'd0;
  assign busy_o            = (state_q != IDLE);
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign out_cnt_o         = out_cnt_q;

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Scoreboard bench for mmu_seq_ctrl: expected bytes and writes are queued
// as stimulus is driven and checked by a negedge monitor.
module tb_mmu_seq_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start_i;
  logic [8:0]  len_i;
  logic [5:0]  in_rd_addr_o;
  logic [31:0] in_rd_data_i;
  logic [7:0]  mmu_input_data_o;
  logic        mmu_valid_input_o;
  logic        mmu_read_ram_i;
  logic [8:0]  mmu_read_data_i;
  logic        mmu_finish_i;
  logic        out_wr_en_o;
  logic [7:0]  out_wr_addr_o;
  logic [31:0] out_wr_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [7:0]  out_cnt_o;

  logic [31:0] mem [64];
  logic [7:0]  exp_byte [$];
  logic [5:0]  exp_addr [$];
  logic [39:0] exp_wr   [$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  always #5 HCLK = ~HCLK;
  assign in_rd_data_i = mem[in_rd_addr_o];

  mmu_seq_ctrl #(.IN_WORDS(64), .OUT_WORDS(4), .TIMEOUT(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start_i(start_i), .len_i(len_i),
    .in_rd_addr_o(in_rd_addr_o), .in_rd_data_i(in_rd_data_i),
    .mmu_input_data_o(mmu_input_data_o), .mmu_valid_input_o(mmu_valid_input_o),
    .mmu_read_ram_i(mmu_read_ram_i), .mmu_read_data_i(mmu_read_data_i),
    .mmu_finish_i(mmu_finish_i), .out_wr_en_o(out_wr_en_o),
    .out_wr_addr_o(out_wr_addr_o), .out_wr_data_o(out_wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .out_cnt_o(out_cnt_o)
  );

  // Monitor: every valid byte and every write is matched against the queues.
  always @(negedge HCLK) begin
    if (mmu_valid_input_o) begin
      n_valid++;
      n_checks++;
      if (exp_byte.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %h addr %0d, none expected", mmu_input_data_o, in_rd_addr_o);
      end else begin
        logic [7:0] eb;
        logic [5:0] ea;
        eb = exp_byte.pop_front();
        ea = exp_addr.pop_front();
        if (mmu_input_data_o !== eb || in_rd_addr_o !== ea) begin
          n_fail++;
          $display("FAIL feed_byte: got %h@%0d, expected %h@%0d", mmu_input_data_o, in_rd_addr_o, eb, ea);
        end
      end
    end else begin
      n_checks++;
      if (mmu_input_data_o !== 8'd0) begin
        n_fail++;
        $display("FAIL idle_data: got %h, expected 00", mmu_input_data_o);
      end
    end
    if (out_wr_en_o) begin
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %h@%0d, none expected", out_wr_data_o, out_wr_addr_o);
      end else begin
        logic [39:0] ew;
        ew = exp_wr.pop_front();
        if ({out_wr_addr_o, out_wr_data_o} !== ew) begin
          n_fail++;
          $display("FAIL write: got %h@%0d, expected %h@%0d", out_wr_data_o, out_wr_addr_o, ew[31:0], ew[39:32]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push_bytes(input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] w;
      w = mem[i / 4];
      exp_byte.push_back(w[8 * (i % 4) +: 8]);
      exp_addr.push_back(6'(i / 4));
    end
  endtask

  task automatic start_job(input int len);
    start_i = 1'b1;
    len_i   = 9'(len);
    tick();
    start_i = 1'b0;
  endtask

  task automatic finish_job();
    mmu_finish_i = 1'b1;
    tick();
    mmu_finish_i = 1'b0;
    tick();
  endtask

  task automatic check_end(input string name, input logic [7:0] cnt, input logic done, input logic err);
    n_checks++;
    if ({out_cnt_o, done_o, err_o, busy_o} !== {cnt, done, err, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_status: cnt=%0d done=%b err=%b busy=%b, expected cnt=%0d done=%b err=%b busy=0",
               name, out_cnt_o, done_o, err_o, busy_o, cnt, done, err);
    end
    n_checks++;
    if (exp_byte.size() != 0 || exp_wr.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes %0d writes left, expected 0", name, exp_byte.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy_o, done_o, err_o, out_wr_en_o, mmu_valid_input_o} !== 5'b0 ||
        mmu_input_data_o !== 8'd0 || in_rd_addr_o !== 6'd0 || out_wr_addr_o !== 8'd0 ||
        out_wr_data_o !== 32'd0 || out_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b we=%b vld=%b data=%h addr=%0d wa=%0d wd=%h cnt=%0d, expected all 0",
               busy_o, done_o, err_o, out_wr_en_o, mmu_valid_input_o, mmu_input_data_o,
               in_rd_addr_o, out_wr_addr_o, out_wr_data_o, out_cnt_o);
    end
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_feed_order();
    int v0;
    v0 = n_valid;
    push_bytes(5);
    start_job(5);
    repeat (6) tick();
    finish_job();
    n_checks++;
    if (n_valid - v0 != 5 || in_rd_addr_o !== 6'd1) begin
      n_fail++;
      $display("FAIL feed_count: valid=%0d addr=%0d, expected valid=5 addr=1", n_valid - v0, in_rd_addr_o);
    end
    check_end("feed", 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_capture();
    push_bytes(2);
    exp_wr.push_back({8'd0, 32'h0000_01FF});
    exp_wr.push_back({8'd1, 32'h0000_0001});
    exp_wr.push_back({8'd2, 32'h0000_00AA});
    start_job(2);
    mmu_read_ram_i = 1'b1; mmu_read_data_i = 9'h1FF;
    tick();
    mmu_read_ram_i = 1'b0;
    tick();
    mmu_read_ram_i = 1'b1; mmu_read_data_i = 9'h001;
    tick();
    mmu_read_data_i = 9'h0AA; mmu_finish_i = 1'b1;
    tick();
    mmu_read_ram_i = 1'b0; mmu_finish_i = 1'b0;
    tick();
    check_end("capture", 8'd3, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int cyc;
    start_job(0);
    cyc = 0;
    while (busy_o && cyc < 100) begin
      cyc++;
      tick();
    end
    n_checks++;
    if (cyc != 17) begin
      n_fail++;
      $display("FAIL timeout_cycles: busy for %0d cycles, expected 17 (16 WAIT + DONE)", cyc);
    end
    check_end("timeout", 8'd0, 1'b1, 1'b1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) exp_wr.push_back({8'(i), 32'(i + 9'h10)});
    start_job(0);
    for (int i = 0; i < 6; i++) begin
      mmu_read_ram_i  = 1'b1;
      mmu_read_data_i = 9'(i + 9'h10);
      tick();
    end
    mmu_read_ram_i = 1'b0;
    finish_job();
    check_end("overflow", 8'd4, 1'b1, 1'b1);
  endtask

  task automatic test_start_busy();
    int v0;
    v0 = n_valid;
    push_bytes(5);
    start_job(5);
    tick();
    start_job(3);
    repeat (5) tick();
    finish_job();
    n_checks++;
    if (n_valid - v0 != 5) begin
      n_fail++;
      $display("FAIL busy_start_count: valid=%0d, expected 5", n_valid - v0);
    end
    check_end("busy_start", 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int v0;
    push_bytes(8);
    start_job(8);
    tick();
    HRESETn = 1'b0;
    exp_byte.delete();
    exp_addr.delete();
    #1;
    n_checks++;
    if ({busy_o, done_o, err_o, mmu_valid_input_o, out_wr_en_o} !== 5'b0 ||
        mmu_input_data_o !== 8'd0 || in_rd_addr_o !== 6'd0 || out_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b vld=%b data=%h addr=%0d cnt=%0d, expected all 0",
               busy_o, mmu_valid_input_o, mmu_input_data_o, in_rd_addr_o, out_cnt_o);
    end
    tick();
    HRESETn = 1'b1;
    tick();
    v0 = n_valid;
    push_bytes(3);
    start_job(3);
    repeat (4) tick();
    finish_job();
    n_checks++;
    if (n_valid - v0 != 3) begin
      n_fail++;
      $display("FAIL midreset_restart: valid=%0d, expected 3", n_valid - v0);
    end
    check_end("midreset", 8'd0, 1'b1, 1'b0);
  endtask

  initial begin
    HRESETn = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    mmu_read_ram_i = 1'b0;
    mmu_read_data_i = '0;
    mmu_finish_i = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 ^ (32'(i) * 32'h0101_0307);
    mem[0] = 32'h4433_2211;
    mem[1] = 32'hDDCC_BB55;
    test_reset();
    test_feed_order();
    test_capture();
    test_timeout();
    test_overflow();
    test_start_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
